// File: rtl/data_reg_arb_pkg.sv
// Shared types and defaults for the registered round-robin arbiter.
package data_reg_arb_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned DATA_W_DEF  = 8;

    // Burst-lock state, used only when the arbiter is built with ARB_LOCK_EN.
    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } arb_state_e;

    // Index that follows idx in a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Rotating-priority picker: first set request at or above the pointer,
// wrapping from NUM_REQ-1 back to 0. Purely combinational.
module rr_prio_pick
    import data_reg_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
    localparam int unsigned SRC_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [SRC_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant_c,
    output logic [SRC_W-1:0]   o_idx_c,
    output logic               o_any_c
);

    int unsigned w_pos;

    // Scan requesters in priority order starting at the pointer; keep the first hit.
    always_comb begin
        o_grant_c = '0;
        o_idx_c   = '0;
        o_any_c   = 1'b0;
        w_pos     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_pos = (32'(i_ptr) + k) % NUM_REQ;
            if (!o_any_c && i_req[w_pos]) begin
                o_any_c          = 1'b1;
                o_grant_c[w_pos] = 1'b1;
                o_idx_c          = SRC_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/data_reg_rr_arbiter.sv
// Round-robin arbiter sharing one registered output stage between NUM_REQ
// valid/ready requesters. Define ARB_LOCK_EN to let a requester hold the
// grant for a multi-word burst terminated by req_last.
module data_reg_rr_arbiter
    import data_reg_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter  int unsigned DATA_W  = DATA_W_DEF,
    localparam int unsigned SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready
);

    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic [SRC_W-1:0]   r_out_src;
    logic [SRC_W-1:0]   r_ptr;

    logic [NUM_REQ-1:0] w_pick_grant;
    logic [SRC_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic [NUM_REQ-1:0] w_grant;
    logic [SRC_W-1:0]   w_idx;
    logic               w_any;
    logic               w_can_load;
    logic               w_xfer;
    logic [DATA_W-1:0]  w_sel_data;
    logic [SRC_W-1:0]   w_ptr_inc;

    rr_prio_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req     (req_valid),
        .i_ptr     (r_ptr),
        .o_grant_c (w_pick_grant),
        .o_idx_c   (w_pick_idx),
        .o_any_c   (w_pick_any)
    );

`ifdef ARB_LOCK_EN
    arb_state_e       r_state;
    logic [SRC_W-1:0] r_lock_src;

    // While locked only the burst owner is eligible, regardless of the picker.
    always_comb begin
        w_grant = w_pick_grant;
        w_idx   = w_pick_idx;
        w_any   = w_pick_any;
        if (r_state == ST_LOCKED) begin
            w_grant             = '0;
            w_idx               = r_lock_src;
            w_any               = req_valid[r_lock_src];
            w_grant[r_lock_src] = req_valid[r_lock_src];
        end
    end
`else
    logic w_unused_last;

    assign w_grant       = w_pick_grant;
    assign w_idx         = w_pick_idx;
    assign w_any         = w_pick_any;
    assign w_unused_last = ^req_last;
`endif

    // Output slot is free when empty or being drained this cycle; forced
    // closed while reset is asserted so no requester sees a stray accept.
    assign w_can_load = (~r_out_valid | out_ready) & rst_n;
    assign w_xfer     = w_any & w_can_load;
    assign req_ready  = w_grant & {NUM_REQ{w_can_load}};
    assign w_sel_data = req_data[32'(w_idx) * DATA_W +: DATA_W];
    assign w_ptr_inc  = SRC_W'(rr_next(32'(w_idx), NUM_REQ));

    // Single-entry output register: load replaces, drain clears valid, data holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_src   <= w_idx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef ARB_LOCK_EN
    // Lock FSM and rr pointer: pointer advances only when a burst ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_UNLOCKED;
            r_lock_src <= '0;
            r_ptr      <= '0;
        end else if (r_state == ST_UNLOCKED) begin
            if (w_xfer) begin
                if (!req_last[w_idx]) begin
                    r_state    <= ST_LOCKED;
                    r_lock_src <= w_idx;
                end else begin
                    r_ptr <= w_ptr_inc;
                end
            end
        end else begin
            if (w_xfer && req_last[w_idx]) begin
                r_state <= ST_UNLOCKED;
                r_ptr   <= w_ptr_inc;
            end
        end
    end
`else
    // Rr pointer moves past the winner of every transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= w_ptr_inc;
        end
    end
`endif

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule
